alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal even values 8..64.
REQ-002 Parameter SHW, default 5, shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 operation  input  4  opcode, encoding per REQ-013.
REQ-008 dataA, dataB  input  WIDTH each  operands.
REQ-009 shamt  input  SHW  shift amount.
REQ-010 out_valid  output  1  result held valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 saida  output  WIDTH  result; zero  output  1  (saida == 0); of  output  1  overflow/divide-by-zero flag.

Function
REQ-013 Opcodes: 0000 add, 0001 sub, 0010 A+1, 0011 A-1, 0100 and, 0101 or, 0110 xor, 0111 not A, 1000 A<<shamt, 1001 A>>shamt logical, 1010 unsigned A<B, 1011 multiply, 1100 unsigned divide, 1101 unsigned remainder, 1110 A>>>shamt arithmetic (new), 1111 signed A<B (new).
REQ-014 Request accepted on a rising edge where in_valid && in_ready; operation, dataA, dataB, shamt SHALL be captured in internal registers at acceptance; later input changes ignored.
REQ-015 States: IDLE, EXEC, DONE; reset state IDLE.
REQ-016 in_ready = (state==IDLE) || (state==DONE && out_ready), combinational.
REQ-017 Single-cycle ops (all except 1011/1100/1101, and 1100/1101 with dataB==0): accepted at edge N -> DONE, out_valid=1 from edge N+1.
REQ-018 Multiply: product of captured dataA[WIDTH/2-1:0] x dataB[WIDTH/2-1:0], unsigned, full WIDTH-bit result; iterative shift-add, one bit per cycle; IDLE->EXEC at edge N, EXEC->DONE at edge N+WIDTH/2.
REQ-019 Divide/remainder: restoring division, one quotient bit per cycle; IDLE->EXEC at edge N, EXEC->DONE at edge N+WIDTH; 1100 returns quotient, 1101 returns remainder.
REQ-020 Divide/remainder with dataB==0: no EXEC; DONE at edge N+1, of=1, saida = all-ones for 1100, captured dataA for 1101.
REQ-021 add: of=1 iff operand signs equal and result sign differs; sub: of=1 iff operand signs differ and result sign differs from dataA; of=0 for all other ops except REQ-020.
REQ-022 All arithmetic modulo 2^WIDTH; compare ops return 1 or 0 zero-extended; undefined opcodes impossible (full 4-bit map).
REQ-023 saida, zero, of SHALL be registered, stable while out_valid=1, and change only on the edge that leaves or enters DONE.
REQ-024 DONE held while out_ready=0 (backpressure); DONE && out_ready && !in_valid -> IDLE, out_valid=0 next cycle.
REQ-025 DONE && out_ready && in_valid -> new request accepted same edge (back-to-back); single-cycle op then keeps out_valid=1 with new result next cycle.
REQ-026 in_valid during EXEC ignored (in_ready=0); no abort mechanism.
REQ-027 out_ready while out_valid=0 has no effect.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, out_valid=0, saida=0, of=0, zero=1, iteration counter 0, regardless of clock.
REQ-029 Reset asserted mid-EXEC discards the operation; no result is ever presented for it.
REQ-030 First request may be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-031 WIDTH=32: add 0x7FFFFFFF+0x00000001 -> one cycle later out_valid=1, saida=0x80000000, of=1, zero=0.
REQ-032 Divide 100/7 accepted edge N -> out_valid rises edge N+32, saida=14; repeat op 1101 -> saida=2; in_ready=0 throughout EXEC.
REQ-033 Divide 5/0 -> out_valid at N+1, saida=0xFFFFFFFF, of=1; op 1101 5%0 -> saida=5, of=1.
REQ-034 Multiply dataA=0xFFFF0003, dataB=0x12340004 -> out_valid at N+16, saida=12; arithmetic shift 0x80000000>>>4 -> 0xF8000000; signed 0xFFFFFFFF<1 -> 1, unsigned op 1010 same operands -> 0.
REQ-035 Hold out_ready=0 for 5 cycles after result -> saida/of/zero unchanged, in_ready=0; then out_ready=1 with in_valid=1 (xor 0xF0F0,0xF0F0) -> next cycle saida=0, zero=1, out_valid=1.
REQ-036 Assert rst_n=0 at divide iteration 10, release -> outputs reset values immediately, out_valid stays 0 until a new request completes.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshake on both sides.
// Single-cycle ops finish on the accepting edge; multiply and divide iterate one bit per cycle.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] saida,
  output logic             zero,
  output logic             of
);

  localparam int unsigned    HALF     = WIDTH / 2;
  localparam logic [SHW:0]   MulIters = (SHW+1)'(HALF);
  localparam logic [SHW:0]   DivIters = (SHW+1)'(WIDTH);
  localparam logic [SHW:0]   CntOne   = (SHW+1)'(1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpInc  = 4'b0010;
  localparam logic [3:0] OpDec  = 4'b0011;
  localparam logic [3:0] OpAnd  = 4'b0100;
  localparam logic [3:0] OpOr   = 4'b0101;
  localparam logic [3:0] OpXor  = 4'b0110;
  localparam logic [3:0] OpNot  = 4'b0111;
  localparam logic [3:0] OpShl  = 4'b1000;
  localparam logic [3:0] OpShr  = 4'b1001;
  localparam logic [3:0] OpSltu = 4'b1010;
  localparam logic [3:0] OpMul  = 4'b1011;
  localparam logic [3:0] OpDiv  = 4'b1100;
  localparam logic [3:0] OpRem  = 4'b1101;
  localparam logic [3:0] OpSra  = 4'b1110;
  localparam logic [3:0] OpSlt  = 4'b1111;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc_q, wrk_q, b_q;
  logic [SHW:0]     cnt_q;
  logic [WIDTH-1:0] saida_q;
  logic             zero_q, of_q;

  logic             accept, b_zero, start_multi, last_iter;
  logic [WIDTH-1:0] sum, dif;
  logic [WIDTH-1:0] single_res;
  logic             single_of;
  logic [WIDTH-1:0] acc_n, wrk_n, b_n, iter_res;
  logic [WIDTH:0]   trial, diff;

  assign in_ready    = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept      = in_valid && in_ready;
  assign b_zero      = (dataB == '0);
  assign start_multi = (operation == OpMul) ||
                       (((operation == OpDiv) || (operation == OpRem)) && !b_zero);
  assign last_iter   = (cnt_q == CntOne);

  assign sum = dataA + dataB;
  assign dif = dataA - dataB;

  // Result of every op that completes on the accepting edge, including divide by zero.
  always_comb begin
    single_res = '0;
    single_of  = 1'b0;
    case (operation)
      OpAdd: begin
        single_res = sum;
        single_of  = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (sum[WIDTH-1] != dataA[WIDTH-1]);
      end
      OpSub: begin
        single_res = dif;
        single_of  = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (dif[WIDTH-1] != dataA[WIDTH-1]);
      end
      OpInc:  single_res = dataA + One;
      OpDec:  single_res = dataA - One;
      OpAnd:  single_res = dataA & dataB;
      OpOr:   single_res = dataA | dataB;
      OpXor:  single_res = dataA ^ dataB;
      OpNot:  single_res = ~dataA;
      OpShl:  single_res = dataA << shamt;
      OpShr:  single_res = dataA >> shamt;
      OpSltu: single_res = {{(WIDTH-1){1'b0}}, (dataA < dataB)};
      OpMul:  single_res = '0;
      OpDiv: begin
        single_res = '1;
        single_of  = 1'b1;
      end
      OpRem: begin
        single_res = dataA;
        single_of  = 1'b1;
      end
      OpSra:  single_res = $signed(dataA) >>> shamt;
      OpSlt:  single_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      default: single_res = '0;
    endcase
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    trial    = {acc_q, wrk_q[WIDTH-1]};
    diff     = trial - {1'b0, b_q};
    acc_n    = acc_q;
    wrk_n    = wrk_q;
    b_n      = b_q;
    iter_res = '0;
    if (op_q == OpMul) begin
      acc_n    = b_q[0] ? (acc_q + wrk_q) : acc_q;
      wrk_n    = wrk_q << 1;
      b_n      = b_q >> 1;
      iter_res = acc_n;
    end else begin
      acc_n    = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      wrk_n    = {wrk_q[WIDTH-2:0], ~diff[WIDTH]};
      iter_res = (op_q == OpRem) ? acc_n : wrk_n;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = start_multi ? StExec : StDone;
        end else if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
      end
      StExec: begin
        if (last_iter) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      acc_q   <= '0;
      wrk_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      saida_q <= '0;
      zero_q  <= 1'b1;
      of_q    <= 1'b0;
    end else if (accept) begin
      op_q  <= operation;
      acc_q <= '0;
      if (operation == OpMul) begin
        wrk_q <= {{HALF{1'b0}}, dataA[HALF-1:0]};
        b_q   <= {{HALF{1'b0}}, dataB[HALF-1:0]};
        cnt_q <= MulIters;
      end else begin
        wrk_q <= dataA;
        b_q   <= dataB;
        cnt_q <= DivIters;
      end
      // A multi-cycle op leaves the previous result visible until it completes.
      if (!start_multi) begin
        saida_q <= single_res;
        zero_q  <= (single_res == '0);
        of_q    <= single_of;
      end
    end else if (state_q == StExec) begin
      acc_q <= acc_n;
      wrk_q <= wrk_n;
      b_q   <= b_n;
      cnt_q <= cnt_q - CntOne;
      if (last_iter) begin
        saida_q <= iter_res;
        zero_q  <= (iter_res == '0);
        of_q    <= 1'b0;
      end
    end
  end

  assign out_valid = (state_q == StDone);
  assign saida     = saida_q;
  assign zero      = zero_q;
  assign of        = of_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed table, handshake corner cases,
// reset during divide, and randomized ops against an arithmetic reference model.
module tb_alu_multicycle;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] saida;
  logic        zero;
  logic        of;

  int errors = 0;
  int checks = 0;

  alu_multicycle #(
    .WIDTH(32),
    .SHW  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .operation(operation),
    .dataA    (dataA),
    .dataB    (dataB),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .saida    (saida),
    .zero     (zero),
    .of       (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ofl;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference behaviour from the opcode table, using wide integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic o);
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint          s;
    o = 1'b0;
    r = '0;
    case (op)
      4'h0: begin s = sa + sb; r = 32'(s); o = (s != longint'($signed(r))); end
      4'h1: begin s = sa - sb; r = 32'(s); o = (s != longint'($signed(r))); end
      4'h2: r = 32'(ua + 1);
      4'h3: r = 32'(ua - 1);
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: r = 32'(ua << sh);
      4'h9: r = 32'(ua >> sh);
      4'hA: r = (ua < ub) ? 32'd1 : 32'd0;
      4'hB: r = 32'((ua % 65536) * (ub % 65536));
      4'hC: if (b == 0) begin r = 32'hFFFF_FFFF; o = 1'b1; end else r = 32'(ua / ub);
      4'hD: if (b == 0) begin r = a; o = 1'b1; end else r = 32'(ua % ub);
      4'hE: r = 32'(sa >>> sh);
      4'hF: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'hB) return 16;
    if ((op == 4'hC || op == 4'hD) && b != 0) return 32;
    return 0;
  endfunction

  // Presents a request and returns #1 after the accepting edge, with inputs scrambled.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input string nm);
    int guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s ready_timeout actual=%0b required=1", nm, in_ready);
    end
    operation = op;
    dataA     = a;
    dataB     = b;
    shamt     = sh;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    operation = 4'($urandom);
    dataA     = $urandom;
    dataB     = $urandom;
    shamt     = 5'($urandom);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] er, input logic eo,
                       input string nm);
    int lat;
    bit bad;
    lat = latency(op, b);
    start_op(op, a, b, sh, nm);
    bad = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    if (lat > 0) chk({nm, " busy"}, 64'(bad), 64'd0);
    chk({nm, " out_valid"}, 64'(out_valid), 64'd1);
    chk({nm, " saida"}, 64'(saida), 64'(er));
    chk({nm, " of"}, 64'(of), 64'(eo));
    chk({nm, " zero"}, 64'(zero), 64'(er == 0));
  endtask

  initial begin
    logic [31:0] r, a, b;
    logic [3:0]  op;
    logic [4:0]  sh;
    logic        o;
    bit          bad;

    vecs[0]  = '{4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b1};
    vecs[1]  = '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0};
    vecs[2]  = '{4'h0, 32'h8000_0000, 32'h8000_0000, 5'd0,  32'h0000_0000, 1'b1};
    vecs[3]  = '{4'h1, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b1};
    vecs[4]  = '{4'h1, 32'd5,         32'd7,         5'd0,  32'hFFFF_FFFE, 1'b0};
    vecs[5]  = '{4'h2, 32'hFFFF_FFFF, 32'h0000_0000, 5'd0,  32'h0000_0000, 1'b0};
    vecs[6]  = '{4'h3, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0};
    vecs[7]  = '{4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0};
    vecs[8]  = '{4'h5, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hFFF0_FFF0, 1'b0};
    vecs[9]  = '{4'h6, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h0FF0_0FF0, 1'b0};
    vecs[10] = '{4'h7, 32'h1234_5678, 32'h0000_0000, 5'd0,  32'hEDCB_A987, 1'b0};
    vecs[11] = '{4'h8, 32'h0000_0001, 32'h0000_0000, 5'd31, 32'h8000_0000, 1'b0};
    vecs[12] = '{4'h9, 32'h8000_0000, 32'h0000_0000, 5'd4,  32'h0800_0000, 1'b0};
    vecs[13] = '{4'hA, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0};
    vecs[14] = '{4'hF, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0};
    vecs[15] = '{4'hE, 32'h8000_0000, 32'h0000_0000, 5'd4,  32'hF800_0000, 1'b0};
    vecs[16] = '{4'hB, 32'hFFFF_0003, 32'h1234_0004, 5'd0,  32'h0000_000C, 1'b0};
    vecs[17] = '{4'hB, 32'h0000_FFFF, 32'h0000_FFFF, 5'd0,  32'hFFFE_0001, 1'b0};
    vecs[18] = '{4'hC, 32'd100,       32'd7,         5'd0,  32'd14,        1'b0};
    vecs[19] = '{4'hD, 32'd100,       32'd7,         5'd0,  32'd2,         1'b0};
    vecs[20] = '{4'hC, 32'd5,         32'd0,         5'd0,  32'hFFFF_FFFF, 1'b1};
    vecs[21] = '{4'hD, 32'd5,         32'd0,         5'd0,  32'd5,         1'b1};
    vecs[22] = '{4'hC, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'hFFFF_FFFF, 1'b0};
    vecs[23] = '{4'hD, 32'hFFFF_FFFF, 32'h10,        5'd0,  32'h0000_000F, 1'b0};
    vecs[24] = '{4'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000, 1'b1};
    vecs[25] = '{4'h0, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'h0000_0000, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operation = '0;
    dataA     = '0;
    dataB     = '0;
    shamt     = '0;
    #12;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset saida", 64'(saida), 64'd0);
    chk("reset of", 64'(of), 64'd0);
    chk("reset zero", 64'(zero), 64'd1);
    chk("reset in_ready", 64'(in_ready), 64'd1);

    // First request rides the first edge after reset release.
    @(negedge clk);
    rst_n     = 1'b1;
    operation = 4'h0;
    dataA     = 32'h7FFF_FFFF;
    dataB     = 32'h0000_0001;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("first_add out_valid", 64'(out_valid), 64'd1);
    chk("first_add saida", 64'(saida), 64'h8000_0000);
    chk("first_add of", 64'(of), 64'd1);
    chk("first_add zero", 64'(zero), 64'd0);

    for (int i = 0; i < 26; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].res, vecs[i].ofl,
            $sformatf("vec%0d", i));
    end

    // Backpressure: drain to idle, then hold the result for five cycles.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    do_op(4'hD, 32'd100, 32'd7, 5'd0, 32'd2, 1'b0, "bp_rem");
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (saida !== 32'd2 || of !== 1'b0 || zero !== 1'b0 || in_ready !== 1'b0 ||
          out_valid !== 1'b1) bad = 1'b1;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    out_ready = 1'b1;
    do_op(4'h6, 32'h0000_F0F0, 32'h0000_F0F0, 5'd0, 32'd0, 1'b0, "bp_xor");

    // Reset during divide iteration 10.
    do_op(4'hC, 32'd5, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, "pre_rst");
    start_op(4'hC, 32'd1000, 32'd3, 5'd0, "rst_div");
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid saida", 64'(saida), 64'd0);
    chk("rst_mid of", 64'(of), 64'd0);
    chk("rst_mid zero", 64'(zero), 64'd1);
    chk("rst_mid in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    chk("rst_no_result", 64'(bad), 64'd0);
    do_op(4'h0, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, "post_rst");

    // Randomized ops with occasional backpressure.
    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      sh = 5'($urandom);
      model(op, a, b, sh, r, o);
      do_op(op, a, b, sh, r, o, $sformatf("rnd%0d op%0h", n, op));
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
          @(posedge clk);
          #1;
          if (saida !== r || of !== o || out_valid !== 1'b1) bad = 1'b1;
        end
        chk($sformatf("rnd%0d hold", n), 64'(bad), 64'd0);
        out_ready = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
